// File: rtl/soc_bus_pkg.sv
// ============================================================================
// Module  : soc_bus_pkg
// Brief   : Shared types, constants and helper functions for the SoC bus fabric
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package soc_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } bus_state_t;

    // Wide enough for any supported data width; users slice [DATA_W-1:0].
    localparam logic [1023:0] BUS_ERR_RDATA = '0;

    // A single-slave fabric still needs a 1-bit index.
    function automatic int IDX_W(input int num_slaves);
        return (num_slaves <= 1) ? 1 : $clog2(num_slaves);
    endfunction

    function automatic int TMO_W(input int timeout_cycles);
        int w;
        w = $clog2(timeout_cycles + 1);
        if (w < 8) begin
            w = 8;
        end
        if (w > 16) begin
            w = 16;
        end
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/soc_bus_interconnect_if.sv
// ============================================================================
// Module  : soc_bus_interconnect_if
// Brief   : Master-side request/response and broadcast slave-side bus signals
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface soc_bus_interconnect_if #(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
);
    logic                         m_valid;
    logic [ADDR_W-1:0]            m_addr;
    logic [DATA_W-1:0]            m_wdata;
    logic [DATA_W/8-1:0]          m_byte_mask;
    logic                         m_write;
    logic                         m_ready;
    logic [DATA_W-1:0]            m_rdata;
    logic                         m_error;

    logic [NUM_SLAVES-1:0]        s_valid;
    logic [ADDR_W-1:0]            s_addr;
    logic [DATA_W-1:0]            s_wdata;
    logic [DATA_W/8-1:0]          s_byte_mask;
    logic                         s_write;
    logic [NUM_SLAVES-1:0]        s_ready;
    logic [NUM_SLAVES*DATA_W-1:0] s_rdata;

    // Fabric view: accepts CPU requests, drives the slave broadcast.
    modport slave (
        input  m_valid, m_addr, m_wdata, m_byte_mask, m_write,
        output m_ready, m_rdata, m_error,
        output s_valid, s_addr, s_wdata, s_byte_mask, s_write,
        input  s_ready, s_rdata
    );

    // Environment view: the CPU master plus the attached targets.
    modport master (
        output m_valid, m_addr, m_wdata, m_byte_mask, m_write,
        input  m_ready, m_rdata, m_error,
        input  s_valid, s_addr, s_wdata, s_byte_mask, s_write,
        output s_ready, s_rdata
    );

endinterface

`default_nettype wire

// File: rtl/soc_addr_decoder.sv
// ============================================================================
// Module  : soc_addr_decoder
// Brief   : Combinational base/mask address decoder, lowest index wins on overlap
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module soc_addr_decoder #(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W     = 32,
    parameter int IDX_BITS   = 2
) (
    input  wire logic [ADDR_W-1:0]            addr,
    input  wire logic [NUM_SLAVES*ADDR_W-1:0] base,
    input  wire logic [NUM_SLAVES*ADDR_W-1:0] mask,
    output logic                              hit,
    output logic [IDX_BITS-1:0]               idx
);

    logic [NUM_SLAVES-1:0] match;

    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_match
        assign match[gi] = ((addr & mask[gi*ADDR_W +: ADDR_W]) == base[gi*ADDR_W +: ADDR_W]);
    end

    // Scan from the top down so the lowest matching index is the last write.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit = 1'b1;
                idx = IDX_BITS'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/soc_bus_interconnect.sv
// ============================================================================
// Module  : soc_bus_interconnect
// Brief   : Single-master, multi-slave address-decoded handshake bus fabric.
//           Optional REQ-phase timeout enabled by defining SOC_BUS_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module soc_bus_interconnect
    import soc_bus_pkg::*;
#(
    parameter int                             NUM_SLAVES     = 4,
    parameter int                             ADDR_W         = 32,
    parameter int                             DATA_W         = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0]   SLAVE_BASE     = {32'h3000_0000, 32'h2000_0000,
                                                                32'h1000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0]   SLAVE_MASK     = {4{32'hF000_0000}},
    parameter int                             TIMEOUT_CYCLES = 255
) (
    input  wire logic                clk,
    input  wire logic                reset,
    soc_bus_interconnect_if.slave    bus
);

    localparam int IDX_BITS = IDX_W(NUM_SLAVES);
    localparam int MASK_W   = DATA_W / 8;

    bus_state_t           state_q, state_d;
    logic [ADDR_W-1:0]    addr_q,  addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [MASK_W-1:0]    mask_q,  mask_d;
    logic                 write_q, write_d;
    logic [IDX_BITS-1:0]  idx_q,   idx_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;

    logic                  dec_hit;
    logic [IDX_BITS-1:0]   dec_idx;
    logic [NUM_SLAVES-1:0] sel_onehot;
    logic                  sel_ready;
    logic [DATA_W-1:0]     sel_rdata;
    logic                  req_timeout;

    soc_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_W     (ADDR_W),
        .IDX_BITS   (IDX_BITS)
    ) u_decoder (
        .addr (bus.m_addr),
        .base (SLAVE_BASE),
        .mask (SLAVE_MASK),
        .hit  (dec_hit),
        .idx  (dec_idx)
    );

    always_comb begin
        sel_onehot        = '0;
        sel_onehot[idx_q] = 1'b1;
    end

    assign sel_ready = bus.s_ready[idx_q];
    assign sel_rdata = bus.s_rdata[idx_q*DATA_W +: DATA_W];

`ifdef SOC_BUS_TIMEOUT_EN
    localparam int CNT_W = TMO_W(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] tmo_q, tmo_d;

    // Counter value k means k stalled REQ cycles have already elapsed.
    assign req_timeout = (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_d = tmo_q;
        if (state_q != REQ) begin
            tmo_d = '0;
        end else if (!sel_ready) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign req_timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        write_d = write_q;
        idx_d   = idx_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (bus.m_valid) begin
                    addr_d  = bus.m_addr;
                    wdata_d = bus.m_wdata;
                    mask_d  = bus.m_byte_mask;
                    write_d = bus.m_write;
                    idx_d   = dec_idx;
                    state_d = dec_hit ? REQ : ERR;
                end
            end
            REQ: begin
                // A ready arriving together with the timeout still completes normally.
                if (sel_ready) begin
                    rdata_d = sel_rdata;
                    state_d = RESP;
                end else if (req_timeout) begin
                    state_d = ERR;
                end
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            write_q <= 1'b0;
            idx_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            write_q <= write_d;
            idx_q   <= idx_d;
            rdata_q <= rdata_d;
        end
    end

    // Strobes decode straight from the state register so reset clears them at once.
    assign bus.s_valid     = (state_q == REQ) ? sel_onehot : '0;
    assign bus.s_addr      = addr_q;
    assign bus.s_wdata     = wdata_q;
    assign bus.s_byte_mask = mask_q;
    assign bus.s_write     = write_q;

    assign bus.m_ready = (state_q == RESP) || (state_q == ERR);
    assign bus.m_error = (state_q == ERR);
    assign bus.m_rdata = (state_q == ERR) ? BUS_ERR_RDATA[DATA_W-1:0] : rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_soc_bus_interconnect.sv
// ============================================================================
// Module  : tb_soc_bus_interconnect
// Brief   : Directed, table-driven self-checking bench for soc_bus_interconnect
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_soc_bus_interconnect;

    logic clk;
    logic reset;

    int checks = 0;
    int errors = 0;

    soc_bus_interconnect_if #(.NUM_SLAVES(4), .ADDR_W(32), .DATA_W(32)) bus ();

    // Slave 3 shares slave 1's window to exercise lowest-index priority.
    soc_bus_interconnect #(
        .NUM_SLAVES     (4),
        .ADDR_W         (32),
        .DATA_W         (32),
        .SLAVE_BASE     ({32'h1000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
        .SLAVE_MASK     ({4{32'hF000_0000}}),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic        write;
        int          wait_n;
        bit          noise;
        logic [3:0]  exp_sv;
        int          exp_svcnt;
        logic        exp_err;
        logic [31:0] exp_rd;
        int          exp_lat;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Drives one access and acts as the target: readies after wait_n REQ cycles.
    task automatic run_txn(input vec_t v, output int lat, output logic [3:0] sv_obs,
                           output int sv_cnt, output logic err, output logic [31:0] rd,
                           output logic [31:0] sa, output logic [31:0] sw,
                           output logic [3:0] sm, output logic swr);
        int cyc;
        lat    = 0;
        sv_obs = '0;
        sv_cnt = 0;
        err    = 1'b0;
        rd     = '0;
        sa = '0; sw = '0; sm = '0; swr = 1'b0;
        @(negedge clk);
        bus.m_valid     = 1'b1;
        bus.m_addr      = v.addr;
        bus.m_wdata     = v.wdata;
        bus.m_byte_mask = v.mask;
        bus.m_write     = v.write;
        bus.s_ready     = '0;
        cyc = 1;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 2) begin
                sa  = bus.s_addr;
                sw  = bus.s_wdata;
                sm  = bus.s_byte_mask;
                swr = bus.s_write;
            end
            if (bus.s_valid != '0) begin
                sv_obs = sv_obs | bus.s_valid;
                sv_cnt++;
            end
            if (bus.m_ready) begin
                lat         = cyc;
                err         = bus.m_error;
                rd          = bus.m_rdata;
                bus.m_valid = 1'b0;
                bus.s_ready = '0;
                break;
            end
            if (bus.s_valid != '0 && sv_cnt > v.wait_n) begin
                bus.s_ready = bus.s_valid;
            end else if (v.noise) begin
                bus.s_ready = ~bus.s_valid;
            end else begin
                bus.s_ready = '0;
            end
        end
        bus.m_valid = 1'b0;
        bus.s_ready = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_vec(input vec_t v);
        int          lat, sv_cnt;
        logic [3:0]  sv_obs, sm;
        logic        err, swr;
        logic [31:0] rd, sa, sw;
        run_txn(v, lat, sv_obs, sv_cnt, err, rd, sa, sw, sm, swr);
        chk({v.nm, ".latency"}, lat, v.exp_lat);
        chk({v.nm, ".s_valid"}, sv_obs, v.exp_sv);
        chk({v.nm, ".s_valid_cycles"}, sv_cnt, v.exp_svcnt);
        chk({v.nm, ".m_error"}, err, v.exp_err);
        chk({v.nm, ".m_rdata"}, rd, v.exp_rd);
        chk({v.nm, ".s_addr"}, sa, v.addr);
        chk({v.nm, ".s_wdata"}, sw, v.wdata);
        chk({v.nm, ".s_byte_mask"}, sm, v.mask);
        chk({v.nm, ".s_write"}, swr, v.write);
    endtask

    vec_t vecs[7];
    int   seen;

    initial begin
        vecs[0] = '{"rd_s0_w0",  32'h0000_0040, 32'h0,          4'hF, 1'b0, 0, 1'b0,
                    4'b0001, 1, 1'b0, 32'hCAFE_F00D, 3};
        vecs[1] = '{"wr_s2_w3",  32'h2000_0004, 32'h1234_5678, 4'b0011, 1'b1, 3, 1'b0,
                    4'b0100, 4, 1'b0, 32'h2222_BBBB, 6};
        vecs[2] = '{"miss_8",    32'h8000_0000, 32'hA5A5_A5A5, 4'hF, 1'b0, 0, 1'b0,
                    4'b0000, 0, 1'b1, 32'h0, 2};
        vecs[3] = '{"overlap",   32'h1000_0008, 32'h0,          4'hF, 1'b0, 1, 1'b0,
                    4'b0010, 2, 1'b0, 32'h1111_AAAA, 4};
        vecs[4] = '{"miss_3",    32'h3000_0000, 32'h0,          4'h1, 1'b1, 0, 1'b1,
                    4'b0000, 0, 1'b1, 32'h0, 2};
        vecs[5] = '{"wr_mask0",  32'h0000_0FFC, 32'hDEAD_BEEF, 4'b0000, 1'b1, 2, 1'b1,
                    4'b0001, 3, 1'b0, 32'hCAFE_F00D, 5};
        vecs[6] = '{"rd_s2_nz",  32'h2FFF_FFFC, 32'h0,          4'hF, 1'b0, 0, 1'b1,
                    4'b0100, 1, 1'b0, 32'h2222_BBBB, 3};

        reset           = 1'b1;
        bus.m_valid     = 1'b0;
        bus.m_addr      = '0;
        bus.m_wdata     = '0;
        bus.m_byte_mask = '0;
        bus.m_write     = 1'b0;
        bus.s_ready     = '0;
        bus.s_rdata     = {32'h3333_CCCC, 32'h2222_BBBB, 32'h1111_AAAA, 32'hCAFE_F00D};

        #12;
        chk("rst.m_ready", bus.m_ready, 1'b0);
        chk("rst.m_error", bus.m_error, 1'b0);
        chk("rst.s_valid", bus.s_valid, 4'b0000);
        chk("rst.m_rdata", bus.m_rdata, 32'h0);
        chk("rst.s_addr", bus.s_addr, 32'h0);
        chk("rst.s_wdata", bus.s_wdata, 32'h0);
        chk("rst.s_byte_mask", bus.s_byte_mask, 4'h0);
        chk("rst.s_write", bus.s_write, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            apply_vec(vecs[i]);
        end

        // m_valid held through RESP is taken as a fresh request in the next IDLE.
        @(negedge clk);
        bus.m_valid = 1'b1;
        bus.m_addr  = 32'h0000_0040;
        bus.m_write = 1'b0;
        @(posedge clk); #1;
        chk("b2b.first_s_valid", bus.s_valid, 4'b0001);
        bus.s_ready = 4'b0001;
        @(posedge clk); #1;
        chk("b2b.first_m_ready", bus.m_ready, 1'b1);
        bus.s_ready = '0;
        @(posedge clk); #1;
        chk("b2b.idle_m_ready", bus.m_ready, 1'b0);
        chk("b2b.idle_s_valid", bus.s_valid, 4'b0000);
        @(posedge clk); #1;
        chk("b2b.second_s_valid", bus.s_valid, 4'b0001);
        bus.m_valid = 1'b0;
        bus.s_ready = 4'b0001;
        @(posedge clk); #1;
        chk("b2b.second_m_ready", bus.m_ready, 1'b1);
        chk("b2b.second_m_rdata", bus.m_rdata, 32'hCAFE_F00D);
        bus.s_ready = '0;
        @(posedge clk); #1;
        chk("b2b.done_m_ready", bus.m_ready, 1'b0);

        // Reset in the middle of REQ, then a stale ready from the old target.
        @(negedge clk);
        bus.m_valid = 1'b1;
        bus.m_addr  = 32'h2000_0010;
        @(posedge clk); #1;
        chk("rstreq.s_valid_before", bus.s_valid, 4'b0100);
        bus.m_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("rstreq.s_valid_async", bus.s_valid, 4'b0000);
        chk("rstreq.s_addr_async", bus.s_addr, 32'h0);
        @(negedge clk);
        reset       = 1'b0;
        bus.s_ready = 4'b0100;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (bus.m_ready || bus.s_valid != '0) begin
                seen++;
            end
        end
        chk("rstreq.stale_ready_ignored", seen, 0);
        bus.s_ready = '0;

`ifdef SOC_BUS_TIMEOUT_EN
        begin
            vec_t tv;
            tv = '{"timeout", 32'h2000_0000, 32'h0, 4'hF, 1'b0, 1000, 1'b0,
                   4'b0100, 8, 1'b1, 32'h0, 10};
            apply_vec(tv);
            apply_vec(vecs[0]);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/soc_bus_interconnect.md
Name: soc_bus_interconnect

Overview:
Parametrised single-master, multi-slave memory bus fabric for the SoC. It replaces the point-to-point CPU-to-RAM wiring with an address-decoded, handshaked bus. It sits between the CPU memory port and up to NUM_SLAVES targets (RAM, boot ROM, GPIO, UART). It adds valid/ready handshaking, per-slave wait states, decode-miss errors and an optional timeout.

Parameters:
NUM_SLAVES, 4, number of slave ports (1..16)
ADDR_W, 32, address width
DATA_W, 32, data width; byte mask width is DATA_W/8
SLAVE_BASE, {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}, packed NUM_SLAVES*ADDR_W base addresses; slave i occupies bits [i*ADDR_W +: ADDR_W]
SLAVE_MASK, {4{32'hF000_0000}}, packed NUM_SLAVES*ADDR_W decode masks; slave i occupies bits [i*ADDR_W +: ADDR_W]
TIMEOUT_CYCLES, 255, maximum cycles spent waiting for s_ready (used only with the optional feature)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
m_valid  in  1  master request valid; held until m_ready
m_addr  in  ADDR_W  master address
m_wdata  in  DATA_W  master write data
m_byte_mask  in  DATA_W/8  byte enables
m_write  in  1  1=write, 0=read
m_ready  out  1  one-cycle response strobe
m_rdata  out  DATA_W  read data, valid while m_ready=1
m_error  out  1  error flag, valid while m_ready=1
s_valid  out  NUM_SLAVES  per-slave request strobe (one-hot or zero)
s_addr  out  ADDR_W  latched address, broadcast to all slaves
s_wdata  out  DATA_W  latched write data, broadcast
s_byte_mask  out  DATA_W/8  latched byte mask, broadcast
s_write  out  1  latched write flag, broadcast
s_ready  in  NUM_SLAVES  per-slave completion
s_rdata  in  NUM_SLAVES*DATA_W  per-slave read data

Behaviour:
- One clock domain on clk. reset is asynchronous and active-high.
- Reset values: state=IDLE; m_ready, m_error and s_valid are 0; m_rdata, s_addr, s_wdata, s_byte_mask and s_write are 0.
- Decode rule: slave i hits when (m_addr & MASK[i]) == BASE[i]. If several slaves hit, the lowest index wins. If none hit, the access is a decode miss.
- IDLE:
  - On m_valid=1, latch addr, wdata, mask, write and the decoded index into s_* registers.
  - Hit: go to REQ. Miss: go to ERR.
- REQ:
  - s_valid[idx]=1 and all other s_valid bits are 0.
  - When s_ready[idx]=1, capture s_rdata[idx] into m_rdata, deassert s_valid and go to RESP.
  - s_ready on non-selected slaves is ignored.
- RESP: m_ready=1 and m_error=0 for exactly one cycle, then go to IDLE.
- ERR: m_ready=1, m_error=1 and m_rdata=0 for one cycle, then go to IDLE.
- Latency: a zero-wait slave gives m_ready 3 cycles after the IDLE accept edge (accept, REQ, RESP). Each wait state adds 1 cycle. A decode miss gives m_ready 2 cycles after accept.
- Back-to-back requests: a new request is accepted only in IDLE. m_valid held high through RESP is treated as a new request on the following IDLE cycle. The master must drop m_valid in the cycle after m_ready if it has no new access.
- Write data and byte mask are forwarded unmodified. A byte mask of 0 on a write is passed through.
- Reset mid-operation: all outputs clear asynchronously and s_valid drops immediately. A slave's later s_ready is ignored.

Optional Feature:
- Macro: SOC_BUS_TIMEOUT_EN.
- When defined:
  - An 8..16-bit counter clears on REQ entry and increments each REQ cycle without s_ready.
  - When it reaches TIMEOUT_CYCLES, s_valid drops and the FSM goes to ERR (m_error=1).
  - s_ready arriving in the same cycle as the timeout wins, so the response is normal.
  - A stale s_ready after a timeout is ignored in IDLE.
- When undefined: there is no counter and REQ waits indefinitely.

Decomposition:
- Package soc_bus_pkg holds:
  - typedef enum bus_state_t {IDLE, REQ, RESP, ERR};
  - function clog2-based IDX_W(NUM_SLAVES);
  - constant BUS_ERR_RDATA = '0.
- Sub-module soc_addr_decoder: purely combinational priority decoder. Inputs: addr, BASE, MASK. Outputs: hit, idx. Instantiated once.

Test Plan:
- Read, slave 0 with zero wait: m_addr=32'h0000_0040, s_rdata[0]=32'hCAFE_F00D → s_valid=4'b0001 for 1 cycle; m_ready 3 cycles after accept; m_rdata=32'hCAFE_F00D; m_error=0.
- Write, slave 2 with 3 wait states: m_addr=32'h2000_0004, m_wdata=32'h1234_5678, mask=4'b0011 → s_addr, s_wdata and s_byte_mask match; s_write=1; s_valid=4'b0100 for 4 cycles; m_ready 6 cycles after accept.
- Decode miss: m_addr=32'h8000_0000 → s_valid never asserts; m_ready=1, m_error=1 and m_rdata=0 exactly 2 cycles after accept.
- Overlap priority: BASE[1]=BASE[3]=32'h1000_0000 with equal masks → only s_valid[1] asserts.
- Reset mid-REQ: assert reset while s_valid[2]=1 → s_valid=0 within the same cycle; after release, s_ready[2]=1 produces no m_ready.
- With SOC_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=8: slave never readies → after 8 REQ cycles, m_error=1 and m_ready=1; a subsequent access to slave 0 completes normally.
